// File: rtl/en_tick_gen_pkg.sv
// Shared types and constants for the enable tick generator.
// State encoding and divisor floor used by en_tick_gen.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned clamp_div(
    input int unsigned d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/en_tick_gen_mod_m_counter.sv
// Modulo counter with sync clear and enable; max_tick
// is high while the count sits at mod_val-1.
module mod_m_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] mod_val,
  output logic         max_tick
);

  logic [N-1:0] cnt_reg;
  logic [N-1:0] cnt_next;

  assign max_tick = (cnt_reg == (mod_val - N'(1)));

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en)
      cnt_next = max_tick ? '0 : cnt_reg + N'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/en_tick_gen.sv
// One-cycle enable strobe generator with start/stop and burst control.
// Define TICK_GEN_RUNTIME_DIV_EN to add a run-time divisor port `div`.
module en_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int M  = 10,
  parameter int N  = 4,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [BW-1:0] burst_len,
`ifdef TICK_GEN_RUNTIME_DIV_EN
  input  logic [N-1:0]  div,
`endif
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] tick_cnt
);

  state_t        state_reg, state_next;
  logic          mode_reg, mode_next;
  logic [BW-1:0] len_reg, len_next;
  logic [BW-1:0] cnt_reg, cnt_next;
  logic          div_clr;
  logic          div_en;
  logic          max_tick;
  logic [N-1:0]  mod_val;

`ifdef TICK_GEN_RUNTIME_DIV_EN
  logic [N-1:0] div_reg;

  // divisor is frozen for the whole run
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_reg <= N'(M);
    else if (state_reg == IDLE && start && !stop)
      div_reg <= N'(clamp_div(32'(div)));
  end

  assign mod_val = div_reg;
`else
  localparam logic [N-1:0] DIV_FIX = N'(M);

  assign mod_val = DIV_FIX;
`endif

  mod_m_counter #(
    .N(N)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .clr     (div_clr),
    .en      (div_en),
    .mod_val (mod_val),
    .max_tick(max_tick)
  );

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign tick     = busy && max_tick;
  assign tick_cnt = cnt_reg;
  assign div_en   = busy;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    div_clr    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          mode_next  = mode;
          len_next   = burst_len;
          cnt_next   = '0;
          div_clr    = 1'b1;
          state_next = (mode && burst_len == '0)
                       ? DONE : RUN;
        end
      end
      RUN: begin
        if (tick)
          cnt_next = cnt_reg + BW'(1);
        if (stop) begin
          state_next = IDLE;
          div_clr    = 1'b1;
        end else if (mode_reg && tick &&
                     cnt_reg == len_reg - BW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_en_tick_gen.sv
// Directed bench for en_tick_gen with a per-cycle expectation queue.
// Two instances: A with M=10, B with M=4.
module tb_en_tick_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] burst_len = '0;
  logic [3:0] div_a = 4'd10;
  logic [3:0] div_b = 4'd4;

  logic       t_a, b_a, d_a;
  logic [7:0] c_a;
  logic       t_b, b_b, d_b;
  logic [7:0] c_b;

  always #5 clk = ~clk;

  en_tick_gen #(.M(10), .N(4), .BW(8)) ua (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .burst_len(burst_len),
`ifdef TICK_GEN_RUNTIME_DIV_EN
    .div      (div_a),
`endif
    .tick     (t_a),
    .busy     (b_a),
    .done     (d_a),
    .tick_cnt (c_a)
  );

  en_tick_gen #(.M(4), .N(4), .BW(8)) ub (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .burst_len(burst_len),
`ifdef TICK_GEN_RUNTIME_DIV_EN
    .div      (div_b),
`endif
    .tick     (t_b),
    .busy     (b_b),
    .done     (d_b),
    .tick_cnt (c_b)
  );

  typedef struct {
    int         c;
    bit         sel;
    logic       t;
    logic       b;
    logic       d;
    bit         cc;
    logic [7:0] n;
  } exp_t;

  exp_t  q[$];
  int    rel = 0;
  int    n_pass = 0;
  int    n_total = 0;
  int    n_fail = 0;
  string scen = "reset";

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input bit sel,
                      input logic t, input logic b,
                      input logic d, input bit cc,
                      input logic [7:0] n);
    exp_t e;
    e.c = c; e.sel = sel; e.t = t; e.b = b;
    e.d = d; e.cc = cc; e.n = n;
    q.push_back(e);
  endtask

  task automatic tick_cycle();
    exp_t  e;
    string p;
    @(negedge clk);
    while (q.size() > 0 && q[0].c == rel) begin
      e = q.pop_front();
      p = $sformatf("%s %s c%0d", scen,
                    e.sel ? "B" : "A", e.c);
      check({p, " tick"}, 32'(e.sel ? t_b : t_a), 32'(e.t));
      check({p, " busy"}, 32'(e.sel ? b_b : b_a), 32'(e.b));
      check({p, " done"}, 32'(e.sel ? d_b : d_a), 32'(e.d));
      if (e.cc)
        check({p, " cnt"}, 32'(e.sel ? c_b : c_a), 32'(e.n));
    end
    rel = rel + 1;
  endtask

  task automatic go(input int c);
    while (rel <= c) tick_cycle();
  endtask

  task automatic drain();
    check({scen, " leftover"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic apply_reset();
    start = 1'b0;
    stop = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst A tick", 32'(t_a), 0);
    check("rst A busy", 32'(b_a), 0);
    check("rst A done", 32'(d_a), 0);
    check("rst A cnt", 32'(c_a), 0);
    check("rst B tick", 32'(t_b), 0);
    check("rst B busy", 32'(b_b), 0);
    check("rst B done", 32'(d_b), 0);
    check("rst B cnt", 32'(c_b), 0);
    apply_reset();

    scen = "cont";
    push(0, 0, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 40; c++)
      push(c, 0, (c % 10) == 0, 1, 0, c == 31, 3);
    for (int c = 41; c <= 55; c++)
      push(c, 0, 0, 0, 0, 1, 4);
    go(0); start = 1; mode = 0;
    go(1); start = 0;
    go(15); start = 1;
    go(16); start = 0;
    go(40); stop = 1;
    go(41); stop = 0;
    go(55);
    drain();

    scen = "burst";
    apply_reset();
    push(0, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++)
      push(c, 1, (c % 4) == 0, 1, 0, c == 5, 1);
    push(13, 1, 0, 0, 1, 1, 3);
    for (int c = 14; c <= 16; c++)
      push(c, 1, 0, 0, 0, 1, 3);
    go(0); start = 1; mode = 1; burst_len = 3;
    go(1); start = 0;
    go(16);
    drain();

    scen = "len0";
    apply_reset();
    push(1, 1, 0, 0, 1, 1, 0);
    for (int c = 2; c <= 5; c++)
      push(c, 1, 0, 0, 0, 1, 0);
    go(0); start = 1; mode = 1; burst_len = 0;
    go(1); start = 0;
    go(5);
    drain();

    scen = "startstop";
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      push(c, 0, 0, 0, 0, 0, 0);
      push(c, 1, 0, 0, 0, 0, 0);
    end
    go(0); start = 1; stop = 1; mode = 0;
    go(1); start = 0; stop = 0;
    go(5);
    drain();

    scen = "arst";
    apply_reset();
    for (int c = 1; c <= 8; c++)
      push(c, 1, (c % 4) == 0, 1, 0, 0, 0);
    go(0); start = 1; mode = 1; burst_len = 5;
    go(1); start = 0;
    go(8);
    drain();
    #2 reset = 1;
    #1;
    check("arst A tick", 32'(t_a), 0);
    check("arst A busy", 32'(b_a), 0);
    check("arst A done", 32'(d_a), 0);
    check("arst A cnt", 32'(c_a), 0);
    check("arst B tick", 32'(t_b), 0);
    check("arst B busy", 32'(b_b), 0);
    check("arst B done", 32'(d_b), 0);
    check("arst B cnt", 32'(c_b), 0);
    apply_reset();

    scen = "cold";
    push(0, 1, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 8; c++)
      push(c, 1, (c % 4) == 0, 1, 0, 0, 0);
    push(9, 1, 0, 0, 1, 1, 2);
    push(10, 1, 0, 0, 0, 1, 2);
    go(0); start = 1; mode = 1; burst_len = 2;
    go(1); start = 0;
    go(10);
    drain();

`ifdef TICK_GEN_RUNTIME_DIV_EN
    scen = "div5";
    apply_reset();
    for (int c = 1; c <= 16; c++)
      push(c, 1, (c % 5) == 0, 1, 0, c == 16, 3);
    div_b = 4'd5;
    go(0); start = 1; mode = 0;
    go(1); start = 0;
    go(16);
    drain();

    scen = "div1";
    apply_reset();
    for (int c = 1; c <= 8; c++)
      push(c, 1, (c % 2) == 0, 1, 0, c == 8, 3);
    div_b = 4'd1;
    go(0); start = 1; mode = 0;
    go(1); start = 0;
    go(8);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
